conv1d_transposer: RTL
======================

// Module: conv1d_transposer
// PURPOSE
//  Receiving end of the conv1d output stream. conv1d emits results filter-major:
//  NUM_FILTERS passes of FRAME_LEN scalars each, last on the final scalar.
//  This block buffers one full frame and re-emits it time-major: FRAME_LEN column
//  vectors of NUM_FILTERS elements, ready for the next conv1d/dense layer.
// PARAMETERS
//  BW           8   element bitwidth (signed)
//  FRAME_LEN    50  time steps per frame
//  NUM_FILTERS  8   filters per frame; output vector length
// PORTS
//  clk_i    in   1               clock
//  rst_n_i  in   1               asynchronous active-low reset
//  data_i   in   BW              signed input element (filter-major order)
//  valid_i  in   1               input valid
//  last_i   in   1               marks final input element of frame
//  ready_o  out  1               input ready
//  data_o   out  NUM_FILTERS*BW  output column; filter f at [f*BW +: BW]
//  valid_o  out  1               output valid
//  last_o   out  1               marks final column (t = FRAME_LEN-1)
//  ready_i  in   1               downstream ready
//  err_o    out  1               sticky framing error flag
// BEHAVIOUR
//  - Storage: NUM_FILTERS x FRAME_LEN flop array of BW bits; zeroed by reset only.
//  - Reset: state FILL, counters t=0/f=0, valid_o=0, last_o=0, data_o=0, err_o=0,
//    ready_o=1 (ready_o is combinational: 1 iff state==FILL).
//  - FILL: transfer when valid_i&&ready_o; write mem[f][t]; t++; at t==FRAME_LEN-1
//    wrap t=0, f++. End of frame = transfer with last_i=1 OR transfer at
//    f==NUM_FILTERS-1,t==FRAME_LEN-1, whichever first. At end: t=0, f=0, go DRAIN.
//  - Framing errors (set err_o, sticky until reset): last_i=1 before final
//    element (early last); final element without last_i (missing last). Both
//    still end the frame. Unwritten entries keep prior contents.
//  - DRAIN: ready_o=0 (single buffer, no fill/drain overlap). valid_o=1,
//    data_o = {mem[NF-1][t],...,mem[0][t]}, last_o = (t==FRAME_LEN-1).
//    Transfer on valid_o&&ready_i: t++; after transfer with last_o, t=0, go FILL
//    (ready_o=1 next cycle).
//  - Output registered: valid_o/data_o/last_o change only on clock edges; while
//    valid_o&&!ready_i they hold stable.
//  - Latency: first column valid the cycle after final input transfer; one
//    column per cycle with ready_i held high; FRAME_LEN cycles to drain.
//  - Values pass through bit-exact (no arithmetic); sign preserved.
//  - Reset asserted mid-operation: immediate return to reset state, frame lost.
// TESTING (bench uses BW=8, FRAME_LEN=4, NUM_FILTERS=2)
//  1 inputs 0..7, last on 7, ready_i=1 -> data_o 16'h0400,16'h0501,16'h0602,
//    16'h0703 on 4 consecutive cycles, last_o on 4th, err_o=0, ready_o=1 after.
//  2 same frame, ready_i toggled 1/0 per cycle -> each column held while
//    stalled, same 4 columns in order, ready_o=0 throughout drain.
//  3 inputs -1,-2..-8 with valid_i gaps every other cycle -> columns 16'hFBFF,
//    16'hFAFE,16'hF9FD,16'hF8FC; no data accepted while valid_i=0.
//  4 early last: 3 inputs 10,11,12 (last on 12) after test 1 -> err_o=1, drain
//    4 columns: 16'h040A,16'h050B,16'h060C,16'h0703.
//  5 missing last: 8 inputs, last_i=0 throughout -> drain starts after 8th,
//    err_o=1, columns as test 1.
//  6 rst_n_i pulsed low during 2nd drain column -> valid_o=0, ready_o=1, err_o=0;
//    fresh frame 0..7 then drains exactly as test 1.

Source files
------------

// File: rtl/conv1d_transposer_if.sv
// Stream bundle for the conv1d transposer: filter-major scalar input side,
// time-major column output side, plus the sticky framing error flag.
interface conv1d_transposer_if #(
    parameter int unsigned BW          = 8,
    parameter int unsigned NUM_FILTERS = 8
);
    logic signed [BW-1:0]             data_i;
    logic                             valid_i;
    logic                             last_i;
    logic                             ready_o;
    logic [NUM_FILTERS*BW-1:0]        data_o;
    logic                             valid_o;
    logic                             last_o;
    logic                             ready_i;
    logic                             err_o;

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, err_o
    );

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, err_o
    );
endinterface

// File: rtl/conv1d_transposer.sv
// Buffers one filter-major conv1d frame and replays it as time-major column
// vectors; single buffer, so filling and draining never overlap.
module conv1d_transposer #(
    parameter int unsigned BW          = 8,
    parameter int unsigned FRAME_LEN   = 50,
    parameter int unsigned NUM_FILTERS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    conv1d_transposer_if.slave   bus
);
    localparam int unsigned TW = (FRAME_LEN > 1)   ? $clog2(FRAME_LEN)   : 1;
    localparam int unsigned FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int unsigned OW = NUM_FILTERS * BW;
    localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);

    typedef enum logic {FILL, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [FW-1:0]   f_q, f_d;
    logic [BW-1:0]   mem_q [NUM_FILTERS][FRAME_LEN];
    logic [BW-1:0]   mem_d [NUM_FILTERS][FRAME_LEN];
    logic [OW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic            last_elem_c;
    logic [TW-1:0]   col_sel;
    logic            load_col;

    assign last_elem_c = (f_q == F_LAST) && (t_q == T_LAST);

    // Next-state: write/advance while filling, step columns while draining
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        f_d      = f_q;
        mem_d    = mem_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        err_d    = err_q;
        col_sel  = '0;
        load_col = 1'b0;

        case (state_q)
            FILL: begin
                if (bus.valid_i) begin
                    mem_d[f_q][t_q] = bus.data_i;
                    // early last or missing last both corrupt framing
                    if (bus.last_i != last_elem_c) err_d = 1'b1;
                    if (bus.last_i || last_elem_c) begin
                        state_d  = DRAIN;
                        t_d      = '0;
                        f_d      = '0;
                        valid_d  = 1'b1;
                        last_d   = (T_LAST == '0);
                        col_sel  = '0;
                        load_col = 1'b1;
                    end else if (t_q == T_LAST) begin
                        t_d = '0;
                        f_d = f_q + FW'(1);
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.ready_i) begin
                    if (last_q) begin
                        state_d = FILL;
                        t_d     = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        t_d      = t_q + TW'(1);
                        last_d   = (t_d == T_LAST);
                        col_sel  = t_d;
                        load_col = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (load_col) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                data_d[i*BW +: BW] = mem_d[FW'(i)][col_sel];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FILL;
            t_q     <= '0;
            f_q     <= '0;
            mem_q   <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            f_q     <= f_d;
            mem_q   <= mem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_o = (state_q == FILL);
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
    assign bus.err_o   = err_q;
endmodule
